// File: rtl/serial_link_arbiter_pkg.sv
// Shared constants and state encoding for the serial link arbiter.
package serial_link_arbiter_pkg;

  localparam int unsigned LenWidth     = 4;
  localparam int unsigned HdrWidth     = 1 + LenWidth;  // ID bit plus length field
  localparam int unsigned PayloadWidth = 16;
  localparam int unsigned IdxWidth     = 2;             // indexes the LenWidth header bits

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StLen,
    StData,
    StGap
  } state_e;

endpackage

// File: rtl/frame_shifter.sv
// Frame datapath: latches the accepted frame, walks the length field MSB first
// and shifts the payload out LSB first while counting remaining payload bits.
module frame_shifter
  import serial_link_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    load_id,
  input  logic [LenWidth-1:0]     load_len,
  input  logic [PayloadWidth-1:0] load_data,
  input  logic                    step_len,
  input  logic                    step_data,
  output logic                    id,
  output logic                    len_bit,
  output logic                    data_bit,
  output logic                    idx_zero,
  output logic                    len_zero,
  output logic                    cnt_last,
  output logic [LenWidth-1:0]     cnt_out
);

  logic                    id_q;
  logic [LenWidth-1:0]     len_q;
  logic [PayloadWidth-1:0] data_q;
  logic [IdxWidth-1:0]     idx_q;
  logic [LenWidth-1:0]     cnt_q;

  // Latch on acceptance, then advance the header index or payload on each step.
  // The header index is primed at load so it already points at the length MSB in LEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= 1'b0;
      len_q  <= '0;
      data_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      id_q   <= load_id;
      len_q  <= load_len;
      data_q <= load_data;
      idx_q  <= IdxWidth'(LenWidth - 1);
      cnt_q  <= load_len;
    end else begin
      if (step_len) begin
        idx_q <= idx_q - 1'b1;
      end
      if (step_data) begin
        data_q <= data_q >> 1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  assign id       = id_q;
  assign len_bit  = len_q[idx_q];
  assign data_bit = data_q[0];
  assign idx_zero = (idx_q == '0);
  assign len_zero = (len_q == '0);
  assign cnt_last = (cnt_q == LenWidth'(1));
  assign cnt_out  = cnt_q;

endmodule

// File: rtl/serial_link_arbiter.sv
// Two-source round-robin arbiter that serialises one frame at a time:
// ID bit, 4-bit length MSB first, then the payload LSB first, then one gap step.
module serial_link_arbiter
  import serial_link_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [LenWidth-1:0]     len0,
  input  logic [LenWidth-1:0]     len1,
  input  logic [PayloadWidth-1:0] data0,
  input  logic [PayloadWidth-1:0] data1,
  output logic                    grant0,
  output logic                    grant1,
  output logic                    serOut,
  output logic                    serOutValid,
  output logic                    busy,
  output logic [LenWidth-1:0]     cnt_out
);

  state_e state_q;
  logic   last_grant_q;
  logic   accept;
  logic   winner;
  logic   sh_id;
  logic   sh_len_bit;
  logic   sh_data_bit;
  logic   sh_idx_zero;
  logic   sh_len_zero;
  logic   sh_cnt_last;

  // Round-robin only matters under contention; a lone requester always wins.
  assign accept = tick && (state_q == StIdle) && (req0 || req1);
  assign winner = (req0 && req1) ? ~last_grant_q : req1;

  frame_shifter u_frame_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_id   (winner),
    .load_len  (winner ? len1 : len0),
    .load_data (winner ? data1 : data0),
    .step_len  (tick && (state_q == StLen)),
    .step_data (tick && (state_q == StData)),
    .id        (sh_id),
    .len_bit   (sh_len_bit),
    .data_bit  (sh_data_bit),
    .idx_zero  (sh_idx_zero),
    .len_zero  (sh_len_zero),
    .cnt_last  (sh_cnt_last),
    .cnt_out   (cnt_out)
  );

  // Frame sequencing FSM with registered grant, busy and valid outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant0       <= 1'b0;
      grant1       <= 1'b0;
      busy         <= 1'b0;
      serOutValid  <= 1'b0;
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              state_q      <= StId;
              last_grant_q <= winner;
              grant0       <= ~winner;
              grant1       <= winner;
              busy         <= 1'b1;
              serOutValid  <= 1'b1;
            end
          end
          StId: state_q <= StLen;
          StLen: begin
            if (sh_idx_zero) begin
              if (sh_len_zero) begin
                state_q     <= StGap;
                serOutValid <= 1'b0;
              end else begin
                state_q <= StData;
              end
            end
          end
          StData: begin
            if (sh_cnt_last) begin
              state_q     <= StGap;
              serOutValid <= 1'b0;
            end
          end
          StGap: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Serial bit is a pure decode of registered state, forced low outside a frame.
  always_comb begin
    serOut = 1'b0;
    unique case (state_q)
      StId:    serOut = sh_id;
      StLen:   serOut = sh_len_bit;
      StData:  serOut = sh_data_bit;
      default: serOut = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed bench for serial_link_arbiter.
module tb_serial_link_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        req0;
  logic        req1;
  logic [3:0]  len0;
  logic [3:0]  len1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        grant0;
  logic        grant1;
  logic        serOut;
  logic        serOutValid;
  logic        busy;
  logic [3:0]  cnt_out;

  int n_pass  = 0;
  int n_total = 0;

  serial_link_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req0        (req0),
    .req1        (req1),
    .len0        (len0),
    .len1        (len1),
    .data0       (data0),
    .data1       (data1),
    .grant0      (grant0),
    .grant1      (grant1),
    .serOut      (serOut),
    .serOutValid (serOutValid),
    .busy        (busy),
    .cnt_out     (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in the ID cycle; leaves the DUT in GAP. Each frame bit lasts per cycles.
  task automatic frame_check(input logic id, input logic [3:0] len, input logic [15:0] data,
                             input int per, input string tag);
    for (int k = 0; k < 5 + int'(len); k++) begin
      logic       eb;
      logic [3:0] ec;
      if (k == 0) eb = id;
      else if (k < 5) eb = len[4-k];
      else eb = data[k-5];
      ec = (k < 5) ? len : len - 4'(k - 5);
      for (int c = 0; c < per; c++) begin
        chk({tag, "_valid"}, 16'(serOutValid), 16'd1);
        chk({tag, "_bit"}, 16'(serOut), 16'(eb));
        chk({tag, "_cnt"}, 16'(cnt_out), 16'(ec));
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        chk({tag, "_g0"}, 16'(grant0), 16'(k == 0 && c == 0 && id == 1'b0));
        chk({tag, "_g1"}, 16'(grant1), 16'(k == 0 && c == 0 && id == 1'b1));
        tick = (c == per - 1);
        step();
      end
    end
    tick = 1'b1;
  endtask

  task automatic gap_check(input string tag);
    chk({tag, "_gap_valid"}, 16'(serOutValid), 16'd0);
    chk({tag, "_gap_bit"}, 16'(serOut), 16'd0);
    chk({tag, "_gap_busy"}, 16'(busy), 16'd1);
    chk({tag, "_gap_cnt"}, 16'(cnt_out), 16'd0);
    chk({tag, "_gap_grant"}, 16'({grant1, grant0}), 16'd0);
  endtask

  initial begin
    rst   = 1'b1;
    tick  = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    len0  = 4'd0;
    len1  = 4'd0;
    data0 = 16'h0000;
    data1 = 16'h0000;
    step();
    step();
    chk("rst_valid", 16'(serOutValid), 16'd0);
    chk("rst_bit", 16'(serOut), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cnt", 16'(cnt_out), 16'd0);
    chk("rst_grant", 16'({grant1, grant0}), 16'd0);
    rst = 1'b0;

    // Single frame: len 3, payload 0x0005.
    req0  = 1'b1;
    len0  = 4'd3;
    data0 = 16'h0005;
    step();
    req0 = 1'b0;
    frame_check(1'b0, 4'd3, 16'h0005, 1, "t029");
    gap_check("t029");
    step();
    chk("t029_idle_busy", 16'(busy), 16'd0);

    // No step without tick: no grant, still idle.
    tick = 1'b0;
    req0 = 1'b1;
    step();
    step();
    chk("hold_grant", 16'({grant1, grant0}), 16'd0);
    chk("hold_busy", 16'(busy), 16'd0);
    req0 = 1'b0;
    tick = 1'b1;

    // Contention from reset alternates 0,1,0 with GAP + IDLE between frames.
    rst = 1'b1;
    step();
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    len0 = 4'd0;
    len1 = 4'd0;
    step();
    frame_check(1'b0, 4'd0, 16'h0000, 1, "t030a");
    gap_check("t030a");
    step();
    chk("t030_idle_busy", 16'(busy), 16'd0);
    chk("t030_idle_grant", 16'({grant1, grant0}), 16'd0);
    step();
    frame_check(1'b1, 4'd0, 16'h0000, 1, "t030b");
    gap_check("t030b");
    step();
    step();
    frame_check(1'b0, 4'd0, 16'h0000, 1, "t030c");
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();

    // Maximum length frame from source 1.
    req1  = 1'b1;
    len1  = 4'd15;
    data1 = 16'hFFFF;
    step();
    req1 = 1'b0;
    frame_check(1'b1, 4'd15, 16'hFFFF, 1, "t031");
    gap_check("t031");
    step();

    // Tick every 4th cycle: bits held, grant stays one cycle.
    req0  = 1'b1;
    len0  = 4'd3;
    data0 = 16'h0005;
    step();
    req0 = 1'b0;
    frame_check(1'b0, 4'd3, 16'h0005, 4, "t032");
    gap_check("t032");
    step();
    chk("t032_idle_busy", 16'(busy), 16'd0);

    // Inputs changed after acceptance must not leak into the frame.
    req0  = 1'b1;
    len0  = 4'd12;
    data0 = 16'h00FF;
    step();
    req0  = 1'b0;
    data0 = 16'hFF00;
    len0  = 4'd5;
    frame_check(1'b0, 4'd12, 16'h00FF, 1, "t034");
    gap_check("t034");
    step();

    // Reset mid-DATA (with tick low) aborts the frame and restores source 0 priority.
    req0  = 1'b1;
    len0  = 4'd10;
    data0 = 16'h03A5;
    step();
    req0 = 1'b0;
    repeat (7) step();
    chk("t033_pre_valid", 16'(serOutValid), 16'd1);
    chk("t033_pre_cnt", 16'(cnt_out), 16'd8);
    rst  = 1'b1;
    tick = 1'b0;
    step();
    chk("t033_valid", 16'(serOutValid), 16'd0);
    chk("t033_bit", 16'(serOut), 16'd0);
    chk("t033_busy", 16'(busy), 16'd0);
    chk("t033_cnt", 16'(cnt_out), 16'd0);
    rst  = 1'b0;
    tick = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    len0 = 4'd0;
    len1 = 4'd0;
    step();
    chk("t033_g0", 16'(grant0), 16'd1);
    chk("t033_g1", 16'(grant1), 16'd0);
    req0 = 1'b0;
    req1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_link_arbiter.md
SERIAL_LINK_ARBITER -- requirements
Module: serial_link_arbiter

Interface
REQ-001 SHALL expose ports: clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL expose: rst  input  1  synchronous active-high reset.
REQ-003 SHALL expose: tick  input  1  step enable, one-cycle pulse from the existing one-pulser or tied high.
REQ-004 SHALL expose: req0, req1  input  1 each  frame request from source 0 / source 1.
REQ-005 SHALL expose: len0, len1  input  4 each  payload length in bits, 0..15.
REQ-006 SHALL expose: data0, data1  input  16 each  payload, transmitted LSB first.
REQ-007 SHALL expose: grant0, grant1  output  1 each  one-cycle pulse marking frame acceptance.
REQ-008 SHALL expose: serOut  output  1  serial line.
REQ-009 SHALL expose: serOutValid  output  1  high while serOut carries a frame bit.
REQ-010 SHALL expose: busy  output  1  high in any state except IDLE.
REQ-011 SHALL expose: cnt_out  output  4  remaining payload bits, for the existing hex_display.

Function
REQ-012 FSM states SHALL be IDLE, ID, LEN, DATA, GAP; every transition SHALL occur only on an edge where tick=1.
REQ-013 Frame SHALL be: 1 ID bit (source number), then 4 LEN bits MSB first, then len payload bits LSB first; total 5+len valid cycles per frame.
REQ-014 In IDLE with tick=1 and any request: latch winner's len/data/id, go to ID, pulse the winner's grant for exactly the next cycle.
REQ-015 Arbitration SHALL be round-robin: if both request, grant the source not granted last; a single requester always wins.
REQ-016 last_grant SHALL update only on acceptance; its reset value is 1, so source 0 wins the first contention.
REQ-017 ID: serOutValid=1, serOut=id; advance to LEN with bit index 3.
REQ-018 LEN: emit len[idx] and decrement idx; after idx 0, go to DATA if len>0, else GAP.
REQ-019 DATA: emit data[0] of the shift register, shift right, decrement cnt_out; after the last bit (cnt_out 1 to 0), go to GAP.
REQ-020 GAP SHALL be one tick-step with serOutValid=0 and serOut=0, then IDLE; requests SHALL NOT be granted in GAP.
REQ-021 Inputs len/data SHALL be ignored after latching; a change mid-frame SHALL NOT affect the frame.
REQ-022 A request held high continuously SHALL yield back-to-back frames separated by exactly one GAP plus one IDLE step.
REQ-023 Outside ID/LEN/DATA, serOutValid=0 and serOut=0; cnt_out SHALL equal the latched len during ID/LEN, decrement in DATA, and be 0 in IDLE/GAP.
REQ-024 With tick=0, all outputs SHALL hold, except grant pulses, which SHALL be 0.

Reset
REQ-025 On rst=1 at an edge: state=IDLE, serOut=0, serOutValid=0, grant0=grant1=0, busy=0, cnt_out=0, last_grant=1.
REQ-026 Reset SHALL take priority over tick and abort any frame in progress with no further valid bits.

Structure
REQ-027 State encoding, frame-header width (5) and payload width (16) SHALL live in a shared package/constants file.
REQ-028 Datapath SHALL be one sub-module, frame_shifter (latch, LEN index, payload shift, cnt_out), controlled by the arbiter FSM.

Verification
REQ-029 tick=1, req0=1, len0=3, data0=16'h0005 -> grant0 pulse, then serOut 0,0,0,1,1,1,0,1 with valid high 8 cycles, then GAP.
REQ-030 req0=req1=1 from reset, len=0 -> grant0 first, frame 0,0,0,0,0, then grant1 with frame 1,0,0,0,0, alternating thereafter.
REQ-031 req1=1, len1=15, data1=16'hFFFF -> 20 valid cycles; cnt_out counts 15 down to 0 during DATA.
REQ-032 tick pulsing every 4th cycle during a frame -> each bit held 4 cycles, grant width is 1 cycle, no bit lost.
REQ-033 rst asserted during DATA of a len=10 frame -> next cycle valid=0, busy=0, cnt_out=0; next request gets source 0 priority.
REQ-034 Change data0 from 16'h00FF to 16'hFF00 mid-frame after acceptance -> transmitted payload matches 16'h00FF.
